// File: rtl/cnn_layer_accel_result_tagger.sv
// Tags each CNN result word with its (row, col, depth) coordinate, depth fastest, and flags the last word.
// One output register, 1-cycle latency; in_ready follows out_ready so the stage holds a full word while stalled.
module cnn_layer_accel_result_tagger #(
    parameter int C_DATA_WIDTH  = 16,
    parameter int C_DIM_WIDTH   = 10,
    parameter int C_DEPTH_WIDTH = 10
) (
    input  logic                     clk_core,
    input  logic                     rst,
    input  logic                     job_start,
    output logic                     job_accept,
    output logic                     job_error,
    input  logic [C_DIM_WIDTH-1:0]   cfg_num_rows,
    input  logic [C_DIM_WIDTH-1:0]   cfg_num_cols,
    input  logic [C_DEPTH_WIDTH-1:0] cfg_num_kernels,
    input  logic                     cfg_upsample,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [C_DATA_WIDTH-1:0]  in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [C_DATA_WIDTH-1:0]  out_data,
    output logic [C_DIM_WIDTH:0]     out_row,
    output logic [C_DIM_WIDTH:0]     out_col,
    output logic [C_DEPTH_WIDTH-1:0] out_depth,
    output logic                     out_last,
    output logic                     job_complete,
    input  logic                     job_complete_ack
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [C_DIM_WIDTH-1:0]   DIM_ONE   = {{(C_DIM_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [C_DEPTH_WIDTH-1:0] DEPTH_ONE = {{(C_DEPTH_WIDTH-1){1'b0}}, 1'b1};

    state_t state_q, state_d;

    logic [C_DIM_WIDTH-1:0]   rows_q, cols_q;
    logic [C_DEPTH_WIDTH-1:0] kern_q;
    logic                     ups_q;

    logic [C_DIM_WIDTH-1:0]   row_q, row_d, col_q, col_d;
    logic [C_DEPTH_WIDTH-1:0] dep_q, dep_d;
    logic                     last_acc_q, last_acc_d;

    logic                     out_valid_q, out_valid_d;
    logic [C_DATA_WIDTH-1:0]  out_data_q;
    logic [C_DIM_WIDTH:0]     out_row_q, out_col_q;
    logic [C_DEPTH_WIDTH-1:0] out_depth_q;
    logic                     out_last_q;

    logic cfg_zero, start_ok, start_bad;
    logic in_acc, out_consume, last_consume;
    logic dep_end, col_end, row_end, word_last;
    logic [C_DIM_WIDTH:0] row_tag, col_tag;

    assign cfg_zero  = (cfg_num_rows == '0) || (cfg_num_cols == '0) || (cfg_num_kernels == '0);
    assign start_ok  = (state_q == S_IDLE) && job_start && !cfg_zero;
    assign start_bad = (state_q == S_IDLE) && job_start && cfg_zero;

    assign in_acc       = in_valid && in_ready;
    assign out_consume  = out_valid_q && out_ready;
    assign last_consume = out_consume && out_last_q;

    assign dep_end   = (dep_q == kern_q - DEPTH_ONE);
    assign col_end   = (col_q == cols_q - DIM_ONE);
    assign row_end   = (row_q == rows_q - DIM_ONE);
    assign word_last = dep_end && col_end && row_end;

    // Upsampled coordinates need the extra MSB, so the shift can never wrap.
    assign row_tag = ups_q ? {row_q, 1'b0} : {1'b0, row_q};
    assign col_tag = ups_q ? {col_q, 1'b0} : {1'b0, col_q};

    always_ff @(posedge clk_core or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_ok)         state_d = S_ACTIVE;
            S_ACTIVE: if (last_consume)     state_d = S_DONE;
            S_DONE:   if (job_complete_ack) state_d = S_IDLE;
            default:                        state_d = S_IDLE;
        endcase
    end

    // rst gates the pulses because job_start may be high while reset is held.
    always_comb begin
        job_accept   = start_ok && !rst;
        job_error    = start_bad && !rst;
        job_complete = (state_q == S_DONE);
        in_ready     = (state_q == S_ACTIVE) && !last_acc_q && (!out_valid_q || out_ready);
    end

    always_comb begin
        row_d      = row_q;
        col_d      = col_q;
        dep_d      = dep_q;
        last_acc_d = last_acc_q;
        if (start_ok) begin
            row_d      = '0;
            col_d      = '0;
            dep_d      = '0;
            last_acc_d = 1'b0;
        end else if (in_acc) begin
            if (word_last) begin
                last_acc_d = 1'b1;
            end
            if (dep_end) begin
                dep_d = '0;
                if (col_end) begin
                    col_d = '0;
                    row_d = row_q + DIM_ONE;
                end else begin
                    col_d = col_q + DIM_ONE;
                end
            end else begin
                dep_d = dep_q + DEPTH_ONE;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        if (in_acc) begin
            out_valid_d = 1'b1;
        end else if (out_consume) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_core or posedge rst) begin
        if (rst) begin
            rows_q     <= '0;
            cols_q     <= '0;
            kern_q     <= '0;
            ups_q      <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
            dep_q      <= '0;
            last_acc_q <= 1'b0;
        end else begin
            if (start_ok) begin
                rows_q <= cfg_num_rows;
                cols_q <= cfg_num_cols;
                kern_q <= cfg_num_kernels;
                ups_q  <= cfg_upsample;
            end
            row_q      <= row_d;
            col_q      <= col_d;
            dep_q      <= dep_d;
            last_acc_q <= last_acc_d;
        end
    end

    always_ff @(posedge clk_core or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_depth_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (in_acc) begin
                out_data_q  <= in_data;
                out_row_q   <= row_tag;
                out_col_q   <= col_tag;
                out_depth_q <= dep_q;
                out_last_q  <= word_last;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign out_depth = out_depth_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_cnn_layer_accel_result_tagger.sv
// Randomized scoreboard bench: expected tags come from nested loops over the job shape, data from accepted inputs.
module tb_cnn_layer_accel_result_tagger;

    localparam int DW   = 16;
    localparam int DIMW = 10;
    localparam int DEPW = 10;

    logic            clk_core = 1'b0;
    logic            rst;
    logic            job_start, job_accept, job_error;
    logic [DIMW-1:0] cfg_num_rows, cfg_num_cols;
    logic [DEPW-1:0] cfg_num_kernels;
    logic            cfg_upsample;
    logic            in_valid, in_ready;
    logic [DW-1:0]   in_data;
    logic            out_valid, out_ready;
    logic [DW-1:0]   out_data;
    logic [DIMW:0]   out_row, out_col;
    logic [DEPW-1:0] out_depth;
    logic            out_last;
    logic            job_complete, job_complete_ack;

    cnn_layer_accel_result_tagger #(
        .C_DATA_WIDTH(DW), .C_DIM_WIDTH(DIMW), .C_DEPTH_WIDTH(DEPW)
    ) dut (
        .clk_core(clk_core), .rst(rst),
        .job_start(job_start), .job_accept(job_accept), .job_error(job_error),
        .cfg_num_rows(cfg_num_rows), .cfg_num_cols(cfg_num_cols),
        .cfg_num_kernels(cfg_num_kernels), .cfg_upsample(cfg_upsample),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_depth(out_depth), .out_last(out_last),
        .job_complete(job_complete), .job_complete_ack(job_complete_ack)
    );

    always #5 clk_core = ~clk_core;

    typedef struct packed {
        logic [DIMW:0]   row;
        logic [DIMW:0]   col;
        logic [DEPW-1:0] dep;
        logic            last;
    } tag_t;

    tag_t          tagq[$];
    logic [DW-1:0] dataq[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            n_out = 0;
    tag_t          last_seen;
    bit            rand_valid = 0;
    bit            rand_ready = 0;
    bit            held = 0;
    logic [63:0]   held_val;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: job order is rows outermost, depth innermost.
    task automatic model_job(input int r, input int c, input int k, input bit u);
        for (int rr = 0; rr < r; rr++)
            for (int cc = 0; cc < c; cc++)
                for (int dd = 0; dd < k; dd++) begin
                    tag_t t;
                    t.row  = u ? (DIMW+1)'(rr * 2) : (DIMW+1)'(rr);
                    t.col  = u ? (DIMW+1)'(cc * 2) : (DIMW+1)'(cc);
                    t.dep  = DEPW'(dd);
                    t.last = (rr == r - 1) && (cc == c - 1) && (dd == k - 1);
                    tagq.push_back(t);
                end
    endtask

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        forever begin
            @(posedge clk_core);
            #1;
            in_data   = DW'($urandom);
            in_valid  = !rand_valid || ($urandom_range(0, 1) == 1);
            out_ready = !rand_ready || ($urandom_range(0, 1) == 1);
        end
    end

    // Monitor: handshakes observed at negedge complete on the following posedge.
    always @(negedge clk_core) begin
        if (rst) begin
            held = 0;
        end else begin
            if (held)
                chk("stall_hold", {out_valid, out_data, out_row, out_col, out_depth, out_last}, held_val);
            if (out_valid && out_ready) begin
                if (tagq.size() == 0 || dataq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: got tag %0h, expected none", {out_row, out_col, out_depth, out_last});
                end else begin
                    tag_t t;
                    logic [DW-1:0] d;
                    t = tagq.pop_front();
                    d = dataq.pop_front();
                    chk("out_data", out_data, d);
                    chk("out_tag", {out_row, out_col, out_depth, out_last}, t);
                end
                n_out++;
                last_seen = {out_row, out_col, out_depth, out_last};
            end
            held     = out_valid && !out_ready;
            held_val = {out_valid, out_data, out_row, out_col, out_depth, out_last};
            if (in_valid && in_ready) dataq.push_back(in_data);
        end
    end

    task automatic chk_quiet(input string name);
        chk({name, "_ctl"}, {out_valid, out_last, in_ready, job_accept, job_error, job_complete}, 64'd0);
        chk({name, "_dat"}, {out_data, out_row, out_col, out_depth}, 64'd0);
    endtask

    task automatic start_job(input int r, input int c, input int k, input bit u);
        @(posedge clk_core);
        #2;
        cfg_num_rows    = DIMW'(r);
        cfg_num_cols    = DIMW'(c);
        cfg_num_kernels = DEPW'(k);
        cfg_upsample    = u;
        job_start       = 1'b1;
        @(negedge clk_core);
        chk("job_accept", job_accept, 1);
        chk("job_error_on_start", job_error, 0);
        model_job(r, c, k, u);
        @(posedge clk_core);
        #2;
        job_start       = 1'b0;
        cfg_num_rows    = DIMW'($urandom_range(1, 7));
        cfg_num_cols    = DIMW'($urandom_range(1, 7));
        cfg_num_kernels = DEPW'($urandom_range(1, 7));
        cfg_upsample    = ~u;
    endtask

    task automatic wait_complete(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_core);
            if (job_complete) break;
        end
        chk({name, "_complete"}, job_complete, 1);
        chk({name, "_drained"}, tagq.size(), 0);
    endtask

    task automatic do_ack;
        @(posedge clk_core);
        #2;
        job_complete_ack = 1'b1;
        @(negedge clk_core);
        chk("complete_before_ack_edge", job_complete, 1);
        @(posedge clk_core);
        #2;
        job_complete_ack = 1'b0;
        @(negedge clk_core);
        chk("complete_cleared", job_complete, 0);
    endtask

    initial begin
        int n0;
        rst = 1'b1;
        job_start = 1'b0;
        job_complete_ack = 1'b0;
        cfg_num_rows = '0;
        cfg_num_cols = '0;
        cfg_num_kernels = '0;
        cfg_upsample = 1'b0;
        repeat (2) @(negedge clk_core);
        chk_quiet("reset");
        @(posedge clk_core);
        #2;
        rst = 1'b0;

        // 2x2x3 streaming at full rate.
        start_job(2, 2, 3, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_core);
            if (out_valid) break;
        end
        chk("stream_first_valid", out_valid, 1);
        for (int i = 1; i < 12; i++) begin
            @(negedge clk_core);
            chk("stream_no_bubble", out_valid && out_ready, 1);
            chk("stream_complete_early", job_complete, 0);
        end
        @(negedge clk_core);
        chk("complete_latency", job_complete, 1);
        chk("stream_drained", tagq.size(), 0);
        do_ack();

        // Upsampled job; an ack raised while the last word drains must be ignored.
        start_job(2, 2, 3, 1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_core);
            if (out_valid && out_ready && out_last) break;
        end
        chk("ups_last_seen", out_valid && out_last, 1);
        job_complete_ack = 1'b1;
        @(posedge clk_core);
        #2;
        job_complete_ack = 1'b0;
        @(negedge clk_core);
        chk("early_ack_ignored", job_complete, 1);
        chk("ups_drained", tagq.size(), 0);
        do_ack();

        // 19x19x1 with random stalls on both sides.
        rand_valid = 1;
        rand_ready = 1;
        n0 = n_out;
        start_job(19, 19, 1, 0);
        wait_complete(6000, "big");
        chk("big_count", n_out - n0, 361);
        chk("big_final_tag", last_seen, {11'd18, 11'd18, 10'd0, 1'b1});
        do_ack();
        rand_valid = 0;
        rand_ready = 0;

        // Zero-sized job is rejected.
        @(posedge clk_core);
        #2;
        cfg_num_rows = 10'd3;
        cfg_num_cols = 10'd0;
        cfg_num_kernels = 10'd2;
        job_start = 1'b1;
        @(negedge clk_core);
        chk("err_pulse", job_error, 1);
        chk("err_no_accept", job_accept, 0);
        @(posedge clk_core);
        #2;
        job_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_core);
            chk("err_after", {job_error, job_accept, in_ready, out_valid}, 0);
        end

        // Completion held without ack; job_start ignored meanwhile.
        start_job(1, 2, 1, 0);
        wait_complete(50, "hold");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_core);
            #2;
            cfg_num_rows = 10'd2;
            cfg_num_cols = 10'd2;
            cfg_num_kernels = 10'd2;
            job_start = 1'b1;
            @(negedge clk_core);
            chk("hold_complete", {job_complete, job_accept, in_ready}, 3'b100);
        end
        job_start = 1'b0;
        do_ack();

        // Reset mid-job, then a 1x1x1 job.
        n0 = n_out;
        start_job(2, 2, 3, 0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_core);
            if (n_out - n0 >= 5) break;
        end
        chk("abort_progress", n_out - n0, 5);
        #2;
        rst = 1'b1;
        job_start = 1'b1;
        cfg_num_rows = 10'd1;
        cfg_num_cols = 10'd1;
        cfg_num_kernels = 10'd1;
        #1;
        chk_quiet("async_reset");
        tagq.delete();
        dataq.delete();
        repeat (3) begin
            @(negedge clk_core);
            chk_quiet("held_reset");
        end
        @(posedge clk_core);
        #2;
        job_start = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_core);
            chk("no_stale_complete", {job_complete, out_valid}, 0);
        end
        start_job(1, 1, 1, 0);
        wait_complete(50, "single");
        chk("single_tag", last_seen, {11'd0, 11'd0, 10'd0, 1'b1});
        do_ack();

        // Random small jobs.
        for (int j = 0; j < 6; j++) begin
            rand_valid = 1'($urandom_range(0, 1));
            rand_ready = 1'($urandom_range(0, 1));
            start_job($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4), 1'($urandom_range(0, 1)));
            wait_complete(2000, "rand");
            do_ack();
        end

        chk("final_data_queue", dataq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
